// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and defaults for the memory port arbiter
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE = 2'b00, WAIT = 2'b01, DONE = 2'b10} state_t;
  typedef enum logic {GNT_I = 1'b0, GNT_D = 1'b1} grant_t;
  localparam int MAX_DATA_STREAK_DEF = 3;
  localparam int STREAK_W = 8;
endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: combinational winner selection between fetch and data ports
module mem_arb_pick
  import mem_arb_pkg::*;
#(
  parameter int MAX_DATA_STREAK = MAX_DATA_STREAK_DEF
) (
  input  logic                i_req,
  input  logic                d_req,
  input  logic [STREAK_W-1:0] streak,
  output grant_t              grant
);
  // data wins unless absent or fetch has waited out a full streak
  always_comb grant = (i_req && (!d_req || streak == STREAK_W'(MAX_DATA_STREAK))) ? GNT_I : GNT_D;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one bus controller between a fetch port and a data port
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MAX_DATA_STREAK = MAX_DATA_STREAK_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_ack,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_be,
  output logic [31:0] d_rdata,
  output logic        d_ack,
  output logic [31:0] m_address,
  output logic [31:0] m_write_data,
  output logic [3:0]  m_byteenable,
  output logic        m_read_select,
  output logic        m_write_select,
  input  logic [31:0] m_read_data,
  input  logic        m_busy
);
  state_t r_state;
  grant_t r_grant;
  logic r_we;
  logic [STREAK_W-1:0] r_streak;
  logic r_i_ack, r_d_ack;
  logic [31:0] r_i_rdata, r_d_rdata;
  grant_t w_pick, w_sel;
  logic w_start;
  mem_arb_pick #(.MAX_DATA_STREAK(MAX_DATA_STREAK)) u_pick (
    .i_req(i_req),
    .d_req(d_req),
    .streak(r_streak),
    .grant(w_pick)
  );
  always_comb begin
    w_start = r_state == IDLE && (i_req || d_req);
    w_sel = r_state == IDLE ? w_pick : r_grant;
    m_address = w_sel == GNT_I ? i_addr : d_addr;
    m_byteenable = w_sel == GNT_I ? 4'hf : d_be;
    m_write_data = w_sel == GNT_I ? 32'h0 : d_wdata;
    m_read_select = !rst && w_start && (w_pick == GNT_I || !d_we);
    m_write_select = !rst && w_start && w_pick == GNT_D && d_we;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_grant <= GNT_I;
      r_we <= 1'b0;
      r_streak <= '0;
      r_i_ack <= 1'b0;
      r_d_ack <= 1'b0;
      r_i_rdata <= '0;
      r_d_rdata <= '0;
    end else begin
      r_i_ack <= 1'b0;
      r_d_ack <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_grant <= w_pick;
            r_we <= d_we;
            r_state <= WAIT;
          end
          // with i_req high a request always starts, so a data pick here is a real grant
          r_streak <= (!i_req || w_pick == GNT_I) ? '0 :
                      (r_streak != STREAK_W'(MAX_DATA_STREAK)) ? r_streak + STREAK_W'(1) : r_streak;
        end
        WAIT: if (!m_busy) begin
          r_state <= DONE;
          if (r_grant == GNT_I) begin
            r_i_ack <= 1'b1;
            r_i_rdata <= m_read_data;
          end else begin
            r_d_ack <= 1'b1;
            if (!r_we) r_d_rdata <= m_read_data;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign i_ack = r_i_ack;
  assign d_ack = r_d_ack;
  assign i_rdata = r_i_rdata;
  assign d_rdata = r_d_rdata;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench with port agents and a bus-controller model
module tb_mem_port_arbiter;
  logic clk = 0, rst = 1, i_req = 0, d_req = 0, d_we = 0, m_busy = 0;
  logic [31:0] i_addr = 0, d_addr = 0, d_wdata = 0, m_read_data = 0;
  logic [3:0] d_be = 0;
  logic [31:0] i_rdata, d_rdata, m_address, m_write_data;
  logic [3:0] m_byteenable;
  logic i_ack, d_ack, m_read_select, m_write_select;
  typedef struct {logic [31:0] addr; logic [3:0] be; logic [31:0] wdata; logic we; logic [31:0] rdata; int lat; int cyc;} txn_t;
  txn_t i_q[$], d_q[$];
  logic gq[$];
  int checks = 0, errors = 0, cyc = 0, i_todo = 0, d_todo = 0, i_n = 0, d_n = 0;
  int exp_lat = -1, busy_n = 0, bcnt = 0, wr_cnt = 0, ack_cnt = 0, w0 = 0, a0 = 0;
  logic i_seen = 0, d_seen = 0, nxt_we = 0;
  logic [3:0] nxt_be = 4'hf;
  logic [31:0] nxt_wdata = 0, last_d_rd = 0;
  mem_port_arbiter #(.MAX_DATA_STREAK(3)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .m_address(m_address), .m_write_data(m_write_data), .m_byteenable(m_byteenable),
    .m_read_select(m_read_select), .m_write_select(m_write_select),
    .m_read_data(m_read_data), .m_busy(m_busy)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] rd_of(input logic [31:0] a);
    return a == 32'h1000 ? 32'hDEADBEEF : a ^ 32'hA5A55A5A;
  endfunction
  function automatic logic [31:0] gpack();
    logic [31:0] v = 0;
    foreach (gq[i]) v = {v[30:0], gq[i]};
    return v;
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  // bus controller: busy for busy_n WAIT cycles, read data derived from address
  always @(negedge clk) begin
    if (rst) begin
      bcnt = 0;
      m_busy = 0;
    end else if (m_read_select || m_write_select) begin
      bcnt = busy_n;
      m_read_data = rd_of(m_address);
      m_busy = busy_n > 0;
    end else begin
      m_busy = bcnt > 0;
      if (bcnt > 0) bcnt--;
    end
  end
  always @(negedge clk) begin
    txn_t t;
    if (!rst) begin
      if (m_read_select || m_write_select) begin
        if (m_address[15:12] == 4'h1) begin
          gq.push_back(1'b0);
          if (i_q.size() == 0) chk("i_cmd_unexp", 1, 0);
          else begin
            t = i_q[0];
            chk("i_cmd_addr", m_address, t.addr);
            chk("i_cmd_be", 32'(m_byteenable), 32'hf);
            chk("i_cmd_wdata", m_write_data, 0);
            chk("i_cmd_sel", {m_read_select, m_write_select}, 2'b10);
            if (t.lat >= 0) chk("i_cmd_cyc", cyc, t.cyc);
          end
        end else begin
          gq.push_back(1'b1);
          if (m_write_select) wr_cnt++;
          if (d_q.size() == 0) chk("d_cmd_unexp", 1, 0);
          else begin
            t = d_q[0];
            chk("d_cmd_addr", m_address, t.addr);
            chk("d_cmd_be", 32'(m_byteenable), 32'(t.be));
            chk("d_cmd_wdata", m_write_data, t.wdata);
            chk("d_cmd_sel", {m_read_select, m_write_select}, t.we ? 2'b01 : 2'b10);
            if (t.lat >= 0) chk("d_cmd_cyc", cyc, t.cyc);
          end
        end
      end
      if (i_ack) begin
        i_seen = 1;
        ack_cnt++;
        if (i_q.size() == 0) chk("i_ack_unexp", 1, 0);
        else begin
          t = i_q.pop_front();
          chk("i_rdata", i_rdata, t.rdata);
          if (t.lat >= 0) chk("i_lat", cyc - t.cyc, t.lat);
        end
      end
      if (d_ack) begin
        d_seen = 1;
        ack_cnt++;
        if (d_q.size() == 0) chk("d_ack_unexp", 1, 0);
        else begin
          t = d_q.pop_front();
          if (!t.we) last_d_rd = t.rdata;
          chk("d_rdata", d_rdata, last_d_rd);
          if (t.lat >= 0) chk("d_lat", cyc - t.cyc, t.lat);
        end
      end
    end
  end
  // each agent drops its request after the ack and may reissue in the same step
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (i_req && i_seen) i_req = 0;
    if (d_req && d_seen) d_req = 0;
    i_seen = 0;
    d_seen = 0;
    if (!i_req && i_todo > 0) begin
      i_req = 1;
      i_addr = 32'h1000 + 32'(4 * i_n);
      i_q.push_back('{i_addr, 4'hf, 32'h0, 1'b0, rd_of(i_addr), exp_lat, cyc});
      i_todo--;
      i_n++;
    end
    if (!d_req && d_todo > 0) begin
      d_req = 1;
      d_addr = 32'h2000 + 32'(4 * d_n);
      d_we = nxt_we;
      d_be = nxt_be;
      d_wdata = nxt_wdata;
      d_q.push_back('{d_addr, d_be, d_wdata, d_we, rd_of(d_addr), exp_lat, cyc});
      d_todo--;
      d_n++;
    end
  endtask
  task automatic run(input int budget);
    int n = 0;
    while ((i_todo > 0 || d_todo > 0 || i_q.size() > 0 || d_q.size() > 0 || i_req || d_req) && n < budget) begin
      step();
      n++;
    end
    chk("done_in_budget", 32'(n < budget), 1);
    repeat (2) step();
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_i_ack", i_ack, 0);
    chk("rst_d_ack", d_ack, 0);
    chk("rst_i_rdata", i_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);
    chk("rst_strobes", {m_read_select, m_write_select}, 0);
    @(posedge clk);
    #1;
    rst = 0;
    exp_lat = 2;
    i_todo = 1;
    run(20);
    exp_lat = -1;
    gq.delete();
    i_todo = 1;
    d_todo = 1;
    run(30);
    chk("simul_cnt", gq.size(), 2);
    chk("simul_order", gpack(), 2'b10);
    gq.delete();
    i_todo = 1;
    d_todo = 5;
    run(80);
    chk("starve_cnt", gq.size(), 6);
    chk("starve_order", gpack(), 6'b111011);
    exp_lat = 6;
    busy_n = 4;
    nxt_we = 1;
    nxt_be = 4'b0011;
    nxt_wdata = 32'h1234;
    w0 = wr_cnt;
    d_todo = 1;
    run(30);
    chk("wr_pulses", wr_cnt - w0, 1);
    busy_n = 0;
    nxt_we = 0;
    nxt_be = 4'hf;
    nxt_wdata = 0;
    exp_lat = 2;
    d_todo = 2;
    run(30);
    exp_lat = -1;
    busy_n = 10;
    i_todo = 1;
    step();
    step();
    step();
    rst = 1;
    step();
    @(negedge clk);
    chk("mid_rst_strobes", {m_read_select, m_write_select}, 0);
    chk("mid_rst_acks", {i_ack, d_ack}, 0);
    chk("mid_rst_i_rdata", i_rdata, 0);
    chk("mid_rst_d_rdata", d_rdata, 0);
    step();
    rst = 0;
    i_req = 0;
    i_seen = 0;
    i_q.delete();
    busy_n = 0;
    last_d_rd = 0;
    a0 = ack_cnt;
    repeat (12) step();
    chk("post_rst_noack", ack_cnt - a0, 0);
    exp_lat = 2;
    i_todo = 1;
    run(20);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
